imm_instr_packer: RTL
=====================

# imm_instr_packer

Two-stage pipelined RV32I instruction word assembler: accepts an opcode, register fields, funct fields, a 32-bit immediate and an immediate type code, and packs the immediate into the type-specific bit positions of a 32-bit instruction word. Performs the inverse of the ID-stage immediate generation and range-checks that the immediate is representable. Sits between the debug/program-loader path and instruction memory: it emits each word with an auto-incrementing word address and drops unrepresentable words with an error pulse and count.

## Interface
Parameters:
- `ERR_CNT_W`, 8, width of saturating error counter.

Ports:
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  reset; one clock; synchronous, active-high.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  request accepted when `in_valid && in_ready` at a rising edge.
- `opcode`  input  7  instr[6:0].
- `rd`, `rs1`, `rs2`  input  5 each  register fields.
- `funct3`  input  3  instr[14:12].
- `funct7`  input  7  instr[31:25], R-type only.
- `imm`  input  32  immediate value, two's complement.
- `imm_type`  input  3  `ITYPE`/`STYPE`/`BTYPE`/`UTYPE`/`JTYPE` codes from Parameters.v; any other code = R-type.
- `load_addr`  input  1  load `addr_in` into the address counter.
- `addr_in`  input  32  new base word address.
- `out_valid`  output  1  `instr`/`addr` valid.
- `out_ready`  input  1  output consumed when `out_valid && out_ready`.
- `instr`  output  32  packed instruction word.
- `addr`  output  32  byte address for `instr`.
- `err_pulse`  output  1  one-cycle pulse per dropped word.
- `err_count`  output  ERR_CNT_W  dropped-word count, saturating.

## Operation
- Packing (rs/funct fields in standard positions):
  - I: {imm[11:0], rs1, funct3, rd, opcode}; error unless imm[31:11] all equal.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; error unless imm[31:11] all equal.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}; error unless imm[0]==0 and imm[31:12] all equal.
  - U: {imm[31:12], rd, opcode}; error unless imm[11:0]==0.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}; error unless imm[0]==0 and imm[31:20] all equal.
  - R/other: {funct7, rs2, rs1, funct3, rd, opcode}; `imm` ignored; never errors.
- Stage 1 (S1) registers the accepted request. Pack and range check are combinational on S1. Stage 2 is the output register.
- An S1 entry with no error moves to the output register when `!out_valid || out_ready`. It is tagged with the current address counter value, and the counter then increments by 4, wrapping 0xFFFFFFFC→0.
- An S1 entry with an error is discarded on the next edge regardless of output backpressure. On that edge `err_pulse` is set for one cycle, `err_count` increments and saturates at all-ones, and the address counter does not advance.
- `in_ready = !s1_valid || s1_leaves`, where `s1_leaves` covers both the advancing and the discarded cases. Full throughput is 1 word/cycle.
- `load_addr` overrides the counter on that edge. A word transferring into stage 2 on the same edge uses the old counter value, and the loaded value is not incremented.

## Timing
- Reset values: `out_valid`=0, `instr`=0, `addr`=0, `err_pulse`=0, `err_count`=0, address counter=0, S1 empty. `in_ready`=1 in the first cycle after reset.
- Reset mid-operation: S1 and the output register are flushed without output and without an error pulse. No word is emitted.
- Latency: a request accepted at edge N gives `out_valid`=1 after edge N+1 if the output is free. A dropped word gives `err_pulse`=1 after edge N+1.
- `instr`/`addr` hold stable while `out_valid && !out_ready`.
- Output full and S1 full with a valid word: `in_ready`=0 until `out_ready`.
- Output full and S1 holding an error word: the word is dropped at the next edge and `in_ready`=1 in that cycle.

## Test plan
- Reset, `load_addr` with 0x100, then ITYPE opcode 0x13, rd=1, rs1=2, funct3=0, imm=-1, with `out_ready`=1 -> `instr`=0xFFF10093, `addr`=0x100, two cycles after acceptance.
- Back-to-back BTYPE (opcode 0x63, rs1=1, rs2=2, imm=-4) then JTYPE (opcode 0x6F, rd=1, imm=0x800) -> words 0xFE208EE3 @0x100 and 0x001000EF @0x104 on consecutive cycles.
- UTYPE imm=0x12345001 -> no output, `err_pulse` for 1 cycle, `err_count`=1, next valid word still gets the next unused address.
- Hold `out_ready`=0 for 5 cycles with a stream of valid words -> `in_ready` drops after two accepts, no word is lost or duplicated, and `instr` is stable.
- 256 error words -> `err_count` stays at 0xFF. `load_addr` with 0xFFFFFFFC, then two valid words -> addresses 0xFFFFFFFC and 0x0.
- Assert `rst` while both stages are full -> no output, `err_count`=0, and `out_valid`=0 the next cycle.
- Random imm/type with self-check: re-extracting the immediate from `instr` equals `imm` for every non-error word.

Source files
------------

// File: rtl/imm_instr_packer.sv
// imm_instr_packer: two-stage RV32I instruction word assembler.
// Packs a two's complement immediate into the type-specific bit positions of
// a 32-bit instruction word and range-checks that the immediate fits. Each
// representable word is emitted with an auto-incrementing byte address.
// Unrepresentable words are dropped with an error pulse and a saturating count.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   request handshake (opcode, rd, rs1, rs2, funct3, funct7,
//                    imm, imm_type)
//   load_addr        load addr_in into the address counter
//   out_valid/ready  output handshake (instr, addr)
//   err_pulse        one-cycle pulse per dropped word
//   err_count        saturating dropped-word count
module imm_instr_packer #(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  input  logic [2:0]           imm_type,
  input  logic                 load_addr,
  input  logic [31:0]          addr_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          instr,
  output logic [31:0]          addr,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [2:0] ITYPE = 3'd1;
  localparam logic [2:0] STYPE = 3'd2;
  localparam logic [2:0] BTYPE = 3'd3;
  localparam logic [2:0] UTYPE = 3'd4;
  localparam logic [2:0] JTYPE = 3'd5;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  imm_type;
  } req_t;

  logic                 s1_valid_q, s1_valid_d;
  req_t                 s1_q, s1_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          instr_q, instr_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          addr_cnt_q, addr_cnt_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        hi11_ok, hi12_ok, hi20_ok;
  logic        s1_adv, s1_drop, accept;

  // Sign-extension checks: the upper bits must all be copies of the sign bit.
  assign hi11_ok = (&s1_q.imm[31:11]) | ~(|s1_q.imm[31:11]);
  assign hi12_ok = (&s1_q.imm[31:12]) | ~(|s1_q.imm[31:12]);
  assign hi20_ok = (&s1_q.imm[31:20]) | ~(|s1_q.imm[31:20]);

  // Pack and range check on the stage-1 entry.
  always_comb begin
    pack_instr = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
    pack_err   = 1'b0;
    case (s1_q.imm_type)
      ITYPE: begin
        pack_instr = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
        pack_err   = ~hi11_ok;
      end
      STYPE: begin
        pack_instr = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                      s1_q.imm[4:0], s1_q.opcode};
        pack_err   = ~hi11_ok;
      end
      BTYPE: begin
        pack_instr = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                      s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
        pack_err   = s1_q.imm[0] | ~hi12_ok;
      end
      UTYPE: begin
        pack_instr = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
        pack_err   = |s1_q.imm[11:0];
      end
      JTYPE: begin
        pack_instr = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                      s1_q.rd, s1_q.opcode};
        pack_err   = s1_q.imm[0] | ~hi20_ok;
      end
      default: ;
    endcase
  end

  // Error entries leave unconditionally; good entries need a free output slot.
  assign s1_adv   = s1_valid_q & ~pack_err & (~out_valid_q | out_ready);
  assign s1_drop  = s1_valid_q & pack_err;
  assign in_ready = ~s1_valid_q | s1_adv | s1_drop;
  assign accept   = in_valid & in_ready;

  // Next-state for both stages, address counter and error reporting.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    addr_cnt_d  = addr_cnt_q;
    err_pulse_d = s1_drop;
    err_count_d = err_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3,
                     funct7: funct7, imm: imm, imm_type: imm_type};
    end else if (s1_adv || s1_drop) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      instr_d     = pack_instr;
      addr_d      = addr_cnt_q;
      addr_cnt_d  = addr_cnt_q + 32'd4;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A load wins over the increment; the moving word already took the old value.
    if (load_addr) begin
      addr_cnt_d = addr_in;
    end

    if (s1_drop && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      addr_cnt_q  <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      addr_cnt_q  <= addr_cnt_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign addr      = addr_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule
